// File: rtl/scan_capture_monitor.sv
// ---------------------------------------------------------------------------
// scan_capture_monitor
//
// Purpose:
//   Watches a chip's scan chain from the 12 MHz board clock domain.
//   - Oversamples the asynchronous scan clock and scan data.
//   - Assembles each scan word in a CAP_WIDTH shift register.
//   - Pushes a word into a HIST_DEPTH-entry history ring on every seg_latch
//     rising edge.
//   - Presents one registered display word. A debounced mode button selects
//     what is shown, and a debounced step button selects the history age.
//
// Ports:
//   clk12MHz      in   1                   system clock
//   rst_n         in   1                   asynchronous active-low reset
//   scan_clk_in   in   1                   scan clock from chip (async)
//   scan_data_out in   1                   scan data from chip (async)
//   seg_latch     in   1                   capture strobe, rising edge (async)
//   button_mode   in   1                   raw mode button
//   button_step   in   1                   raw history-step button
//   disp_word     out  CAP_WIDTH           registered display word
//   disp_mode     out  2                   0 LIVE, 1 LATEST, 2 HISTORY, 3 COUNT
//   hist_age      out  $clog2(HIST_DEPTH)  history age shown in HISTORY mode
//   latch_count   out  8                   saturating count of latches
//   new_latch     out  1                   one-cycle pulse per pushed word
// ---------------------------------------------------------------------------
module scan_capture_monitor #(
    parameter int CAP_WIDTH     = 8,
    parameter int HIST_DEPTH    = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 19
) (
    input  logic                          clk12MHz,
    input  logic                          rst_n,
    input  logic                          scan_clk_in,
    input  logic                          scan_data_out,
    input  logic                          seg_latch,
    input  logic                          button_mode,
    input  logic                          button_step,
    output logic [CAP_WIDTH-1:0]          disp_word,
    output logic [1:0]                    disp_mode,
    output logic [$clog2(HIST_DEPTH)-1:0] hist_age,
    output logic [7:0]                    latch_count,
    output logic                          new_latch
);

    localparam int PW = $clog2(HIST_DEPTH);
    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;

    typedef enum logic [1:0] {
        MODE_LIVE    = 2'd0,
        MODE_LATEST  = 2'd1,
        MODE_HISTORY = 2'd2,
        MODE_COUNT   = 2'd3
    } mode_t;

    // Synchroniser bit order: 0 scan clk, 1 scan data, 2 seg_latch,
    // 3 mode button, 4 step button.
    logic [SYNC_STAGES-1:0][4:0] r_sync;
    logic [4:0]                  w_rawIn;
    logic [4:0]                  w_synced;

    logic                        r_sclkPrev;
    logic                        r_latchPrev;
    logic                        w_sclkRise;
    logic                        w_latchRise;

    logic [CAP_WIDTH-1:0]        r_shift;
    logic [CAP_WIDTH-1:0]        r_ring [HIST_DEPTH];
    logic [PW-1:0]               r_wrPtr;
    logic [7:0]                  r_latchCount;
    logic                        r_newLatch;

    // Index 0 = mode button, index 1 = step button.
    logic [1:0]                  r_btnAcc;
    logic [DEBOUNCE_BITS-1:0]    r_btnCnt [2];
    logic [1:0]                  w_btnSync;
    logic [1:0]                  w_press;

    mode_t                       r_mode;
    logic [PW-1:0]               r_histAge;
    logic [CAP_WIDTH-1:0]        r_dispWord;

    logic [PW-1:0]               w_rdLatest;
    logic [PW-1:0]               w_rdHist;
    logic [CAP_WIDTH-1:0]        w_dispNext;

    assign w_rawIn   = {button_step, button_mode, seg_latch, scan_data_out, scan_clk_in};
    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign w_btnSync = w_synced[4:3];

    assign w_sclkRise  = w_synced[0] & ~r_sclkPrev;
    assign w_latchRise = w_synced[2] & ~r_latchPrev;

    // A press is the cycle in which the accepted level flips from 0 to 1.
    always_comb begin
        w_press = '0;
        for (int b = 0; b < 2; b++) begin
            w_press[b] = (w_btnSync[b] != r_btnAcc[b]) && (r_btnCnt[b] == DB_MAX) && w_btnSync[b];
        end
    end

    // Ring pointers wrap naturally because HIST_DEPTH is a power of two.
    assign w_rdLatest = r_wrPtr - PW'(1);
    assign w_rdHist   = r_wrPtr - PW'(1) - r_histAge;

    always_comb begin
        w_dispNext = '0;
        case (r_mode)
            MODE_LIVE:    w_dispNext = r_shift;
            MODE_LATEST:  w_dispNext = r_ring[w_rdLatest];
            MODE_HISTORY: w_dispNext = r_ring[w_rdHist];
            MODE_COUNT:   w_dispNext = CAP_WIDTH'(r_latchCount);
            default:      w_dispNext = '0;
        endcase
    end

    // Synchronisers and edge-detect history.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync      <= '0;
            r_sclkPrev  <= 1'b0;
            r_latchPrev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], w_rawIn};
            r_sclkPrev  <= w_synced[0];
            r_latchPrev <= w_synced[2];
        end
    end

    // Capture path. The ring write uses the pre-shift value when a scan edge
    // and a latch edge coincide, because both read r_shift before it updates.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_wrPtr      <= '0;
            r_latchCount <= '0;
            r_newLatch   <= 1'b0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_ring[i] <= '0;
            end
        end else begin
            r_newLatch <= w_latchRise;
            if (w_sclkRise) begin
                r_shift <= {r_shift[CAP_WIDTH-2:0], w_synced[1]};
            end
            if (w_latchRise) begin
                r_ring[r_wrPtr] <= r_shift;
                r_wrPtr         <= r_wrPtr + PW'(1);
                if (r_latchCount != 8'hFF) begin
                    r_latchCount <= r_latchCount + 8'd1;
                end
            end
        end
    end

    // Debounce. The counter only runs while the synchronised level disagrees
    // with the accepted level, so a button held through reset must be seen
    // stable for the whole period before it counts as pressed.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_btnAcc <= '0;
            for (int b = 0; b < 2; b++) begin
                r_btnCnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_btnSync[b] != r_btnAcc[b]) begin
                    if (r_btnCnt[b] == DB_MAX) begin
                        r_btnAcc[b] <= w_btnSync[b];
                        r_btnCnt[b] <= '0;
                    end else begin
                        r_btnCnt[b] <= r_btnCnt[b] + 1'b1;
                    end
                end else begin
                    r_btnCnt[b] <= '0;
                end
            end
        end
    end

    // Display mode and history age. A mode press takes priority and drops any
    // step press from the same cycle.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_mode    <= MODE_LIVE;
            r_histAge <= '0;
        end else begin
            if (w_press[0]) begin
                r_mode <= mode_t'(r_mode + 2'd1);
                if (r_mode == MODE_LATEST) begin
                    r_histAge <= '0;
                end
            end else if (w_press[1] && (r_mode == MODE_HISTORY)) begin
                r_histAge <= r_histAge + PW'(1);
            end
        end
    end

    // Output display register, one clock behind its selected source.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_dispWord <= '0;
        end else begin
            r_dispWord <= w_dispNext;
        end
    end

    assign disp_word   = r_dispWord;
    assign disp_mode   = r_mode;
    assign hist_age    = r_histAge;
    assign latch_count = r_latchCount;
    assign new_latch   = r_newLatch;

endmodule

// File: tb/tb_scan_capture_monitor.sv
// ---------------------------------------------------------------------------
// tb_scan_capture_monitor
//
// Purpose:
//   Directed testbench for scan_capture_monitor with DEBOUNCE_BITS=4.
//   Inputs are driven 1 time unit after each rising clock edge, and outputs
//   are sampled at that same point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_scan_capture_monitor;

    logic       clk12MHz = 1'b0;
    logic       rst_n;
    logic       scan_clk_in;
    logic       scan_data_out;
    logic       seg_latch;
    logic       button_mode;
    logic       button_step;
    logic [7:0] disp_word;
    logic [1:0] disp_mode;
    logic [1:0] hist_age;
    logic [7:0] latch_count;
    logic       new_latch;

    int nCompared   = 0;
    int nMismatched = 0;

    scan_capture_monitor #(
        .CAP_WIDTH     (8),
        .HIST_DEPTH    (4),
        .SYNC_STAGES   (2),
        .DEBOUNCE_BITS (4)
    ) dut (
        .clk12MHz      (clk12MHz),
        .rst_n         (rst_n),
        .scan_clk_in   (scan_clk_in),
        .scan_data_out (scan_data_out),
        .seg_latch     (seg_latch),
        .button_mode   (button_mode),
        .button_step   (button_step),
        .disp_word     (disp_word),
        .disp_mode     (disp_mode),
        .hist_age      (hist_age),
        .latch_count   (latch_count),
        .new_latch     (new_latch)
    );

    always #5 clk12MHz = ~clk12MHz;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk12MHz);
            #1;
        end
    endtask

    // One scan bit: 8 clocks low with data set up, then 8 clocks high.
    task automatic sendBit(input logic b);
        scan_data_out = b;
        scan_clk_in   = 1'b0;
        tick(8);
        scan_clk_in   = 1'b1;
        tick(8);
    endtask

    // Scan word, first bit ends up as the MSB.
    task automatic sendWord(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            sendBit(w[i]);
        end
    endtask

    // Raise seg_latch for ticksEach clocks then drop it for ticksEach clocks,
    // counting new_latch pulses and noting when the first one appears.
    task automatic pulseLatch(input int ticksEach, output int pulses, output int firstAt);
        pulses  = 0;
        firstAt = 0;
        seg_latch = 1'b1;
        for (int i = 1; i <= 2 * ticksEach; i++) begin
            if (i == ticksEach + 1) seg_latch = 1'b0;
            tick(1);
            if (new_latch) begin
                pulses++;
                if (firstAt == 0) firstAt = i;
            end
        end
    endtask

    task automatic pressMode();
        button_mode = 1'b1;
        tick(24);
        button_mode = 1'b0;
        tick(24);
    endtask

    task automatic pressStep();
        button_step = 1'b1;
        tick(24);
        button_step = 1'b0;
        tick(24);
    endtask

    task automatic pressBoth();
        button_mode = 1'b1;
        button_step = 1'b1;
        tick(24);
        button_mode = 1'b0;
        button_step = 1'b0;
        tick(24);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        scan_clk_in   = 1'b0;
        scan_data_out = 1'b0;
        seg_latch     = 1'b0;
        button_mode   = 1'b0;
        button_step   = 1'b0;
        tick(3);
        nCompared++;
        if ({disp_word, disp_mode, hist_age, latch_count, new_latch} !== 21'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got word=%h mode=%0d age=%0d cnt=%0d nl=%b, want all 0",
                     disp_word, disp_mode, hist_age, latch_count, new_latch);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_shift();
        logic [6:0] first7;
        first7 = 7'b1011001;
        for (int i = 6; i >= 0; i--) sendBit(first7[i]);
        nCompared++;
        if (disp_word !== 8'h59) begin
            nMismatched++;
            $display("[TB] FAIL shift_partial: got %h want 59", disp_word);
        end
        scan_data_out = 1'b0;
        scan_clk_in   = 1'b0;
        tick(8);
        scan_clk_in = 1'b1;
        tick(3);
        nCompared++;
        if (disp_word !== 8'h59) begin
            nMismatched++;
            $display("[TB] FAIL shift_latency_early: got %h want 59", disp_word);
        end
        tick(1);
        nCompared++;
        if (disp_word !== 8'hB2) begin
            nMismatched++;
            $display("[TB] FAIL shift_word: got %h want b2", disp_word);
        end
        tick(4);
    endtask

    task automatic test_history();
        int pulses, firstAt;
        for (int w = 1; w <= 5; w++) begin
            sendWord(8'(w));
            pulseLatch(6, pulses, firstAt);
            nCompared++;
            if (pulses != 1 || firstAt != 3) begin
                nMismatched++;
                $display("[TB] FAIL latch_pulse%0d: got pulses=%0d at=%0d want 1 at 3", w, pulses, firstAt);
            end
        end
        nCompared++;
        if (latch_count !== 8'd5) begin
            nMismatched++;
            $display("[TB] FAIL latch_count5: got %0d want 5", latch_count);
        end
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd1 || disp_word !== 8'h05) begin
            nMismatched++;
            $display("[TB] FAIL latest: got mode=%0d word=%h want 1/05", disp_mode, disp_word);
        end
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd2 || hist_age !== 2'd0 || disp_word !== 8'h05) begin
            nMismatched++;
            $display("[TB] FAIL hist_age0: got mode=%0d age=%0d word=%h want 2/0/05", disp_mode, hist_age, disp_word);
        end
        for (int a = 1; a <= 4; a++) begin
            pressStep();
            nCompared++;
            if (hist_age !== 2'(a) || disp_word !== ((a == 4) ? 8'h05 : 8'(5 - a))) begin
                nMismatched++;
                $display("[TB] FAIL hist_step%0d: got age=%0d word=%h want %0d/%h",
                         a, hist_age, disp_word, a % 4, (a == 4) ? 8'h05 : 8'(5 - a));
            end
        end
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd3 || disp_word !== 8'd5) begin
            nMismatched++;
            $display("[TB] FAIL count_mode: got mode=%0d word=%h want 3/05", disp_mode, disp_word);
        end
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL mode_wrap: got %0d want 0", disp_mode);
        end
    endtask

    task automatic test_same_cycle();
        sendWord(8'h3C);
        scan_data_out = 1'b1;
        scan_clk_in   = 1'b0;
        tick(8);
        scan_clk_in = 1'b1;
        seg_latch   = 1'b1;
        tick(8);
        seg_latch = 1'b0;
        tick(8);
        nCompared++;
        if (disp_word !== 8'h79) begin
            nMismatched++;
            $display("[TB] FAIL same_cycle_shift: got %h want 79", disp_word);
        end
        pressMode();
        nCompared++;
        if (disp_word !== 8'h3C || latch_count !== 8'd6) begin
            nMismatched++;
            $display("[TB] FAIL same_cycle_ring: got word=%h cnt=%0d want 3c/6", disp_word, latch_count);
        end
        pressMode();
        pressStep();
        nCompared++;
        if (disp_word !== 8'h05) begin
            nMismatched++;
            $display("[TB] FAIL same_cycle_age1: got %h want 05", disp_word);
        end
        pressMode();
        pressMode();
    endtask

    task automatic test_debounce();
        for (int i = 0; i < 5; i++) begin
            button_mode = 1'b1;
            tick(3);
            button_mode = 1'b0;
            tick(3);
        end
        nCompared++;
        if (disp_mode !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL bounce_rejected: got mode=%0d want 0", disp_mode);
        end
        button_mode = 1'b1;
        tick(24);
        button_mode = 1'b0;
        tick(24);
        nCompared++;
        if (disp_mode !== 2'd1) begin
            nMismatched++;
            $display("[TB] FAIL bounce_one_step: got mode=%0d want 1", disp_mode);
        end
        pressMode();
        pressMode();
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL four_presses: got mode=%0d want 0", disp_mode);
        end
        pressStep();
        nCompared++;
        if (hist_age !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL step_ignored_live: got age=%0d want 0", hist_age);
        end
    endtask

    task automatic test_simultaneous();
        pressMode();
        pressBoth();
        nCompared++;
        if (disp_mode !== 2'd2 || hist_age !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL both_enter_hist: got mode=%0d age=%0d want 2/0", disp_mode, hist_age);
        end
        pressBoth();
        nCompared++;
        if (disp_mode !== 2'd3 || hist_age !== 2'd0) begin
            nMismatched++;
            $display("[TB] FAIL both_step_dropped: got mode=%0d age=%0d want 3/0", disp_mode, hist_age);
        end
        pressMode();
    endtask

    task automatic test_saturation();
        int pulses, firstAt;
        int total;
        total = 0;
        for (int i = 0; i < 300; i++) begin
            pulseLatch(4, pulses, firstAt);
            total += pulses;
        end
        nCompared++;
        if (total != 300) begin
            nMismatched++;
            $display("[TB] FAIL sat_pulses: got %0d want 300", total);
        end
        nCompared++;
        if (latch_count !== 8'hFF) begin
            nMismatched++;
            $display("[TB] FAIL sat_count: got %0d want 255", latch_count);
        end
        pressMode();
        pressMode();
        pressMode();
        nCompared++;
        if (disp_mode !== 2'd3 || disp_word !== 8'hFF) begin
            nMismatched++;
            $display("[TB] FAIL sat_display: got mode=%0d word=%h want 3/ff", disp_mode, disp_word);
        end
        pressMode();
    endtask

    task automatic test_reset_midword();
        pressMode();
        pressMode();
        pressStep();
        pressStep();
        nCompared++;
        if (disp_mode !== 2'd2 || hist_age !== 2'd2) begin
            nMismatched++;
            $display("[TB] FAIL pre_reset_state: got mode=%0d age=%0d want 2/2", disp_mode, hist_age);
        end
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({disp_word, disp_mode, hist_age, latch_count, new_latch} !== 21'd0) begin
            nMismatched++;
            $display("[TB] FAIL async_reset: got word=%h mode=%0d age=%0d cnt=%0d nl=%b, want all 0",
                     disp_word, disp_mode, hist_age, latch_count, new_latch);
        end
        scan_clk_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        sendWord(8'hA5);
        tick(4);
        nCompared++;
        if (disp_word !== 8'hA5 || disp_mode !== 2'd0 || latch_count !== 8'd0) begin
            nMismatched++;
            $display("[TB] FAIL post_reset_word: got word=%h mode=%0d cnt=%0d want a5/0/0",
                     disp_word, disp_mode, latch_count);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_history();
        test_same_cycle();
        test_debounce();
        test_simultaneous();
        test_saturation();
        test_reset_midword();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
